// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: instruction handshake plus tile control and datapath-mode bundle
interface layer_sequencer_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int CFG_WIDTH = 16
);
  logic instr_valid;
  logic instr_ready;
  logic [INSTRUCTION_WIDTH-1:0] instruction_signal;
  logic tile_done;
  logic err_clr;
  logic tile_start;
  logic [1:0] layer_mode;
  logic layer_signal;
  logic [CFG_WIDTH-1:0] cfg_out;
  logic busy;
  logic layer_done;
  logic err_illegal;
  modport master (
    output instr_valid, instruction_signal, tile_done, err_clr,
    input instr_ready, tile_start, layer_mode, layer_signal, cfg_out, busy, layer_done, err_illegal
  );
  modport slave (
    input instr_valid, instruction_signal, tile_done, err_clr,
    output instr_ready, tile_start, layer_mode, layer_signal, cfg_out, busy, layer_done, err_illegal
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: decodes layer instructions and sequences one tile_start per tile until the layer completes
module layer_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int COUNT_WIDTH = 12,
  parameter int CFG_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  layer_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d, done_q, done_d;
  logic [1:0] mode_q, mode_d;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
  logic err_q, err_d;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [COUNT_WIDTH-1:0] count;
  logic accept, legal, illegal;
  assign opcode = bus.instruction_signal[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign count = bus.instruction_signal[INSTRUCTION_WIDTH-OPCODE_WIDTH-1 -: COUNT_WIDTH];
  assign accept = bus.instr_valid && state_q == IDLE;
  assign legal = accept && opcode != '0 && opcode <= OPCODE_WIDTH'(3);
  assign illegal = accept && opcode > OPCODE_WIDTH'(3);
  // next state: decode in IDLE, alternate ISSUE/WAIT per tile, DONE pulses once; illegal set beats err_clr
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    done_d = done_q;
    mode_d = mode_q;
    cfg_d = cfg_q;
    err_d = illegal ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
    case (state_q)
      IDLE: if (legal) begin
        state_d = count != '0 ? ISSUE : DONE;
        total_d = count;
        done_d = '0;
        mode_d = opcode[1:0] - 2'd1;
        cfg_d = bus.instruction_signal[CFG_WIDTH-1:0];
      end
      ISSUE: state_d = WAIT;
      WAIT: if (bus.tile_done) begin
        done_d = done_q + COUNT_WIDTH'(1);
        state_d = done_d == total_q ? DONE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and latched layer context; reset aborts any layer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      total_q <= '0;
      done_q <= '0;
      mode_q <= '0;
      cfg_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      done_q <= done_d;
      mode_q <= mode_d;
      cfg_q <= cfg_d;
      err_q <= err_d;
    end
  end
  assign bus.instr_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.tile_start = state_q == ISSUE;
  assign bus.layer_done = state_q == DONE;
  assign bus.layer_mode = mode_q;
  assign bus.layer_signal = mode_q == 2'd2;
  assign bus.cfg_out = cfg_q;
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: transaction-level reference model checks of layer_sequencer
module tb_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  layer_sequencer_if #(.INSTRUCTION_WIDTH(32), .CFG_WIDTH(16)) bus ();
  layer_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_done = 0;
  logic [1:0] exp_mode = '0;
  logic [15:0] exp_cfg = '0;
  logic exp_err = 1'b0;
  // pulse counters sampled at each rising edge
  always @(posedge clk) begin
    if (bus.tile_start) n_start++;
    if (bus.layer_done) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.instr_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_start"}, bus.tile_start, 0);
    chk({tag, "_done"}, bus.layer_done, 0);
    chk({tag, "_mode"}, bus.layer_mode, 0);
    chk({tag, "_signal"}, bus.layer_signal, 0);
    chk({tag, "_cfg"}, bus.cfg_out, 0);
    chk({tag, "_err"}, bus.err_illegal, 0);
  endtask
  // one instruction from offer to completion; dly/spur < 0 means random, abort_at >= 0 resets in WAIT of that tile
  task automatic run_layer(input logic [31:0] w, input logic clr, input int dly, input int spur, input bit hold, input int abort_at);
    logic [3:0] op;
    int cnt, s0, d0, bad;
    bit legal;
    op = w[31:28];
    cnt = int'(w[27:16]);
    legal = op >= 1 && op <= 3;
    s0 = n_start;
    d0 = n_done;
    bad = 0;
    chk("ready_idle", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instruction_signal = w;
    bus.err_clr = clr;
    bus.tile_done = 1'($urandom % 2);
    step;
    if (!hold) bus.instr_valid = 1'b0;
    bus.err_clr = 1'b0;
    bus.tile_done = 1'b0;
    exp_err = op > 3 ? 1'b1 : clr ? 1'b0 : exp_err;
    if (legal) begin
      exp_mode = op[1:0] - 2'd1;
      exp_cfg = w[15:0];
    end
    chk("err", bus.err_illegal, exp_err);
    chk("mode", bus.layer_mode, exp_mode);
    chk("signal", bus.layer_signal, exp_mode == 2);
    chk("cfg", bus.cfg_out, exp_cfg);
    chk("busy", bus.busy, legal);
    if (legal && cnt == 0) begin
      chk("zero_start", bus.tile_start, 0);
      chk("zero_done", bus.layer_done, 1);
    end
    if (legal) for (int t = 0; t < cnt; t++) begin
      if (!bus.tile_start || bus.layer_done) bad++;
      bus.tile_done = spur < 0 ? 1'($urandom % 2) : spur != 0;
      step;
      bus.tile_done = 1'b0;
      if (t == abort_at) begin
        rst = 1'b1;
        step;
        rst = 1'b0;
        exp_mode = '0;
        exp_cfg = '0;
        exp_err = 1'b0;
        chk_reset_outputs("abort");
        step;
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_starts", n_start - s0, t + 1);
        chk("abort_timing", bad, 0);
        return;
      end
      repeat (dly < 0 ? $urandom_range(2) : dly) begin
        if (bus.tile_start || !bus.busy || bus.instr_ready) bad++;
        step;
      end
      bus.tile_done = 1'b1;
      step;
      bus.tile_done = 1'b0;
    end
    if (legal) begin
      chk("layer_done", bus.layer_done, 1);
      bus.tile_done = 1'($urandom % 2);
      step;
      bus.tile_done = 1'b0;
    end
    chk("ready_after", bus.instr_ready, 1);
    chk("done_clear", bus.layer_done, 0);
    chk("starts", n_start - s0, legal ? cnt : 0);
    chk("dones", n_done - d0, legal);
    chk("timing", bad, 0);
  endtask
  initial begin
    logic [3:0] op;
    bus.instr_valid = 1'b0;
    bus.instruction_signal = '0;
    bus.tile_done = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) step;
    rst = 1'b0;
    chk_reset_outputs("reset");
    run_layer(32'h1003_00A5, 1'b0, 1, 0, 1'b0, -1);
    run_layer(32'h3001_0102, 1'b0, 1, 1, 1'b0, -1);
    run_layer(32'h7000_0000, 1'b0, 0, 0, 1'b0, -1);
    run_layer(32'h0000_1234, 1'b0, 0, 0, 1'b0, -1);
    run_layer(32'h2000_0000, 1'b0, 0, 0, 1'b0, -1);
    run_layer(32'h9000_0000, 1'b1, 0, 0, 1'b0, -1);
    bus.err_clr = 1'b1;
    step;
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr_alone", bus.err_illegal, 0);
    run_layer(32'h1005_0033, 1'b0, 0, 0, 1'b0, 1);
    run_layer(32'h2002_0044, 1'b0, -1, -1, 1'b0, -1);
    repeat (40) begin
      op = 4'($urandom_range(0, 5));
      if (op > 3) op = 4'($urandom_range(4, 15));
      run_layer({op, 12'($urandom_range(0, 6)), 16'($urandom)}, 1'($urandom % 4 == 0), -1, -1, 1'b0, -1);
      repeat ($urandom_range(0, 2)) step;
    end
    run_layer(32'h1FFF_0001, 1'b0, 0, 0, 1'b1, -1);
    run_layer(32'h1FFF_0001, 1'b0, 0, 0, 1'b1, -1);
    bus.instr_valid = 1'b0;
    step;
    chk("final_idle", bus.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
